// File: rtl/inp_debounce.sv
// Switch-vector conditioner: a two-flop synchroniser, then a whole-vector debounce,
// then a change pulse and a pending/ack/overrun handshake toward the processor.
module inp_debounce #(
    parameter int WIDTH           = 16,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic             clock,
    input  logic             n_reset,
    input  logic [WIDTH-1:0] inp,
    input  logic             inp_ack,
    output logic [WIDTH-1:0] inpval,
    output logic             inp_changed,
    output logic             inp_pending,
    output logic             inp_overrun
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] inpval_q, inpval_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             changed_q;
    logic             pending_q, pending_d;
    logic             overrun_q, overrun_d;
    logic             accept;

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        prev_d   = prev_q;
        cnt_d    = cnt_q;
        inpval_d = inpval_q;
        accept   = 1'b0;
        if (sync2_q != prev_q) begin
            prev_d = sync2_q;
            cnt_d  = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (prev_q != inpval_q) begin
            accept   = 1'b1;
            inpval_d = prev_q;
        end
    end

    // An ack in the accept cycle consumes the old event; the new one becomes pending.
    always_comb begin
        pending_d = pending_q;
        overrun_d = overrun_q;
        if (accept) begin
            pending_d = 1'b1;
            if (inp_ack) begin
                overrun_d = 1'b0;
            end else if (pending_q) begin
                overrun_d = 1'b1;
            end
        end else if (inp_ack) begin
            pending_d = 1'b0;
            overrun_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them sample pre-edge values.
    always_ff @(posedge clock) begin
        if (!n_reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            prev_q    <= '0;
            cnt_q     <= '0;
            inpval_q  <= '0;
            changed_q <= 1'b0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            sync1_q   <= inp;
            sync2_q   <= sync1_q;
            prev_q    <= prev_d;
            cnt_q     <= cnt_d;
            inpval_q  <= inpval_d;
            changed_q <= accept;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    assign inpval      = inpval_q;
    assign inp_changed = changed_q;
    assign inp_pending = pending_q;
    assign inp_overrun = overrun_q;

endmodule

// File: tb/tb_inp_debounce.sv
// Bench for inp_debounce (DEBOUNCE_CYCLES=4): vector table, hand-written corner sequences,
// and random stimulus checked every cycle against a sliding-window reference model.
module tb_inp_debounce;

    localparam int W  = 16;
    localparam int DB = 4;
    localparam int HN = DB + 3;

    logic          clock = 1'b0;
    logic          n_reset = 1'b0;
    logic [W-1:0]  inp = '0;
    logic          inp_ack = 1'b0;
    logic [W-1:0]  inpval;
    logic          inp_changed;
    logic          inp_pending;
    logic          inp_overrun;

    inp_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(DB), .CNT_W(16)) dut (
        .clock       (clock),
        .n_reset     (n_reset),
        .inp         (inp),
        .inp_ack     (inp_ack),
        .inpval      (inpval),
        .inp_changed (inp_changed),
        .inp_pending (inp_pending),
        .inp_overrun (inp_overrun)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: hist[k] is the input sampled k edges ago. A value is accepted
    // once the DB+1 samples taken 2..DB+2 edges ago all agree and differ from inpval.
    logic [W-1:0] hist [HN];
    logic [W-1:0] m_val = '0;
    logic         m_chg = 1'b0;
    logic         m_pend = 1'b0;
    logic         m_ovr = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_edge();
        logic stable;
        logic acc;
        if (!n_reset) begin
            for (int i = 0; i < HN; i++) hist[i] = '0;
            m_val = '0; m_chg = 1'b0; m_pend = 1'b0; m_ovr = 1'b0;
        end else begin
            for (int i = HN - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = inp;
            stable = 1'b1;
            for (int i = 3; i < HN; i++) if (hist[i] != hist[2]) stable = 1'b0;
            acc = stable && (hist[2] != m_val);
            m_chg = acc;
            if (acc) m_val = hist[2];
            if (acc && inp_ack) begin
                m_pend = 1'b1; m_ovr = 1'b0;
            end else if (acc) begin
                m_ovr = m_ovr | m_pend; m_pend = 1'b1;
            end else if (inp_ack) begin
                m_pend = 1'b0; m_ovr = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
        check("model_inpval", 32'(inpval), 32'(m_val));
        check("model_changed", 32'(inp_changed), 32'(m_chg));
        check("model_pending", 32'(inp_pending), 32'(m_pend));
        check("model_overrun", 32'(inp_overrun), 32'(m_ovr));
    endtask

    // Ticks until inpval equals v (bounded) and checks the accept landed on edge 6.
    task automatic wait_accept(input string name, input logic [W-1:0] v);
        int idx;
        idx = -1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (inpval == v) begin
                idx = i;
                break;
            end
        end
        check({name, "_latency"}, 32'(idx), 32'(DB + 2));
        check({name, "_pulse"}, 32'(inp_changed), 32'd1);
    endtask

    typedef struct {
        logic [W-1:0] v;
        logic         ack;
        int           hold;
        logic [W-1:0] exp_val;
        int           exp_pulses;
        logic         exp_pend;
        logic         exp_ovr;
    } vec_t;

    vec_t vecs [14];

    initial begin
        for (int i = 0; i < HN; i++) hist[i] = '0;

        vecs[0]  = '{16'h0000, 1'b0, 10, 16'h0000, 1, 1'b1, 1'b0};
        vecs[1]  = '{16'h0000, 1'b1,  3, 16'h0000, 0, 1'b0, 1'b0};
        vecs[2]  = '{16'h0003, 1'b0, 10, 16'h0003, 1, 1'b1, 1'b0};
        vecs[3]  = '{16'h0007, 1'b0, 10, 16'h0007, 1, 1'b1, 1'b1};
        vecs[4]  = '{16'h0007, 1'b1,  3, 16'h0007, 0, 1'b0, 1'b0};
        vecs[5]  = '{16'h0000, 1'b0, 10, 16'h0000, 1, 1'b1, 1'b0};
        vecs[6]  = '{16'h0000, 1'b1,  2, 16'h0000, 0, 1'b0, 1'b0};
        vecs[7]  = '{16'h0001, 1'b0,  3, 16'h0000, 0, 1'b0, 1'b0};
        vecs[8]  = '{16'h0000, 1'b0, 12, 16'h0000, 0, 1'b0, 1'b0};
        vecs[9]  = '{16'h0001, 1'b0,  4, 16'h0000, 0, 1'b0, 1'b0};
        vecs[10] = '{16'h0000, 1'b0, 12, 16'h0000, 0, 1'b0, 1'b0};
        vecs[11] = '{16'h0001, 1'b0,  5, 16'h0000, 0, 1'b0, 1'b0};
        vecs[12] = '{16'h0000, 1'b0, 12, 16'h0000, 2, 1'b1, 1'b1};
        vecs[13] = '{16'h0000, 1'b1,  2, 16'h0000, 0, 1'b0, 1'b0};

        // Reset with all switches on: outputs stay clear, then a fresh change is reported.
        inp = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_inpval", 32'(inpval), 32'h0);
            check("rst_flags", {29'd0, inp_changed, inp_pending, inp_overrun}, 32'h0);
        end
        n_reset = 1'b1;
        wait_accept("rst_release", 16'hFFFF);
        tick();
        check("rst_pulse_end", 32'(inp_changed), 32'd0);
        check("rst_pending", 32'(inp_pending), 32'd1);
        inp_ack = 1'b1;
        tick();
        inp_ack = 1'b0;
        check("rst_ack_clears", 32'(inp_pending), 32'd0);

        foreach (vecs[r]) begin
            int pulses;
            pulses = 0;
            inp = vecs[r].v;
            for (int c = 0; c < vecs[r].hold; c++) begin
                inp_ack = (c == 0) ? vecs[r].ack : 1'b0;
                tick();
                if (inp_changed) pulses++;
            end
            inp_ack = 1'b0;
            check($sformatf("vec%0d_inpval", r), 32'(inpval), 32'(vecs[r].exp_val));
            check($sformatf("vec%0d_pulses", r), 32'(pulses), 32'(vecs[r].exp_pulses));
            check($sformatf("vec%0d_pending", r), 32'(inp_pending), 32'(vecs[r].exp_pend));
            check($sformatf("vec%0d_overrun", r), 32'(inp_overrun), 32'(vecs[r].exp_ovr));
        end

        // 0000 -> 00A5 held: accept on edge 6, pulse for one cycle only.
        inp = 16'h00A5;
        wait_accept("a5", 16'h00A5);
        tick();
        check("a5_pulse_end", 32'(inp_changed), 32'd0);
        inp_ack = 1'b1;
        tick();
        inp_ack = 1'b0;
        check("a5_ack", 32'(inp_pending), 32'd0);
        inp = 16'h0000;
        for (int i = 0; i < 10; i++) tick();
        inp_ack = 1'b1;
        tick();
        inp_ack = 1'b0;

        // Bit 0 bouncing every 2 cycles, then held high: exactly one accept.
        begin
            int pulses;
            pulses = 0;
            for (int i = 0; i < 20; i++) begin
                inp = ((i / 2) % 2 == 0) ? 16'h0001 : 16'h0000;
                tick();
                if (inp_changed) pulses++;
            end
            check("bounce_no_pulse", 32'(pulses), 32'd0);
            check("bounce_inpval", 32'(inpval), 32'h0000);
        end
        inp = 16'h0001;
        wait_accept("bounce", 16'h0001);

        // Ack lands on the exact accept edge while an older event is still pending.
        inp = 16'h0003;
        for (int i = 0; i < DB + 2; i++) tick();
        check("ackacc_before", 32'(inpval), 32'h0001);
        inp_ack = 1'b1;
        tick();
        inp_ack = 1'b0;
        check("ackacc_inpval", 32'(inpval), 32'h0003);
        check("ackacc_changed", 32'(inp_changed), 32'd1);
        check("ackacc_pending", 32'(inp_pending), 32'd1);
        check("ackacc_overrun", 32'(inp_overrun), 32'd0);
        tick();
        check("ackacc_hold_pend", 32'(inp_pending), 32'd1);
        inp_ack = 1'b1;
        tick();
        inp_ack = 1'b0;
        check("ackacc_cleared", 32'(inp_pending), 32'd0);

        // Reset in the middle of a count: progress is discarded.
        inp = 16'h00F0;
        for (int i = 0; i < 3; i++) tick();
        n_reset = 1'b0;
        for (int i = 0; i < 2; i++) tick();
        check("midrst_inpval", 32'(inpval), 32'h0);
        check("midrst_flags", {29'd0, inp_changed, inp_pending, inp_overrun}, 32'h0);
        n_reset = 1'b1;
        wait_accept("midrst", 16'h00F0);

        // Random phase, checked only through the model inside tick().
        begin
            int hold_left;
            logic [W-1:0] v;
            hold_left = 0;
            v = '0;
            for (int c = 0; c < 3000; c++) begin
                if (hold_left == 0) begin
                    case ($urandom_range(0, 4))
                        0: v = 16'h0000;
                        1: v = 16'h00A5;
                        2: v = 16'hFFFF;
                        3: v = 16'h0001;
                        default: v = 16'($urandom);
                    endcase
                    hold_left = $urandom_range(1, 9);
                end
                hold_left--;
                inp = v;
                inp_ack = ($urandom_range(0, 9) == 0);
                n_reset = ($urandom_range(0, 499) != 0);
                tick();
            end
            inp_ack = 1'b0;
            n_reset = 1'b1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
